// File: rtl/axi_lite_regbank_pkg.sv
// axi_lite_regbank_pkg
//   Shared constants and types for the AXI4-Lite register bank: response
//   codes, fabric-port operation codes, write/read channel state types and
//   the helper that derives the word-address LSB from the data width.
package axi_lite_regbank_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] REG_OP_IDLE  = 2'd0;
    localparam logic [1:0] REG_OP_READ  = 2'd1;
    localparam logic [1:0] REG_OP_WRITE = 2'd2;
    localparam logic [1:0] REG_OP_SET   = 2'd3;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    // Number of byte-offset address bits below the register index.
    function automatic int unsigned addr_lsb(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/axi_lite_regbank_if.sv
// axi_lite_regbank_if
//   AXI4-Lite bus bundle (AW, W, B, AR, R channels).
//   slave  : register bank side (receives AW/W/AR, drives B/R and readies)
//   master : interconnect / testbench side
interface axi_lite_regbank_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 6
);
    logic [ADDR_W-1:0]   AWADDR;
    logic [2:0]          AWPROT;
    logic                AWVALID;
    logic                AWREADY;
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WVALID;
    logic                WREADY;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;
    logic [ADDR_W-1:0]   ARADDR;
    logic [2:0]          ARPROT;
    logic                ARVALID;
    logic                ARREADY;
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                RVALID;
    logic                RREADY;

    modport slave (
        input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
               ARADDR, ARPROT, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport master (
        output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
               ARADDR, ARPROT, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

endinterface

// File: rtl/axi_lite_regbank_wr_channel.sv
// axi_lite_regbank_wr_channel
//   AXI4-Lite write path: independent AW/W capture with held flags, the
//   W_IDLE/W_RESP FSM and BRESP generation.
//   Ports:
//     i_clk, i_rst      clock, asynchronous active-high reset
//     s_axi             AW, W and B channel members of the bus
//     o_commit_ok       one-cycle pulse: an OKAY write commits on this edge
//     o_commit_idx      register index of the commit
//     o_commit_data     write data of the commit
//     o_commit_strb     byte enables of the commit
module axi_lite_regbank_wr_channel
    import axi_lite_regbank_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 6,
    parameter int unsigned N  = 8,
    parameter logic [N-1:0] RO_MASK = '0,
    localparam int unsigned ADDR_LSB = addr_lsb(DW),
    localparam int unsigned IW = AW - ADDR_LSB
) (
    input  logic                i_clk,
    input  logic                i_rst,
    axi_lite_regbank_if.slave   s_axi,
    output logic                o_commit_ok,
    output logic [IW-1:0]       o_commit_idx,
    output logic [DW-1:0]       o_commit_data,
    output logic [DW/8-1:0]     o_commit_strb
);

    w_state_t           r_state, w_next;
    logic               r_aw_held, r_w_held, w_aw_held_n, w_w_held_n;
    logic [AW-1:0]      r_awaddr;
    logic [DW-1:0]      r_wdata;
    logic [DW/8-1:0]    r_wstrb;
    logic               r_awready, r_wready, r_bvalid;
    logic [1:0]         r_bresp;
    logic               w_aw_hs, w_w_hs, w_commit, w_slverr;
    logic [AW-1:0]      w_addr;
    logic [IW-1:0]      w_idx;
    logic [(1<<IW)-1:0] w_ro_ext;
    logic               w_unused_aw;

    assign w_aw_hs = s_axi.AWVALID && r_awready;
    assign w_w_hs  = s_axi.WVALID && r_wready;

    // Held values take precedence; otherwise use the live handshake.
    assign w_addr        = r_aw_held ? r_awaddr : s_axi.AWADDR;
    assign o_commit_data = r_w_held  ? r_wdata  : s_axi.WDATA;
    assign o_commit_strb = r_w_held  ? r_wstrb  : s_axi.WSTRB;
    assign w_idx         = w_addr[AW-1:ADDR_LSB];
    assign o_commit_idx  = w_idx;

    assign w_commit = (r_state == W_IDLE) && (r_aw_held || w_aw_hs)
                                          && (r_w_held  || w_w_hs);

    // Indices beyond the register count read as 1, folding the range check
    // into the read-only lookup.
    always_comb begin
        w_ro_ext        = '1;
        w_ro_ext[N-1:0] = RO_MASK;
    end
    assign w_slverr    = w_ro_ext[w_idx];
    assign o_commit_ok = w_commit && !w_slverr;

    assign w_unused_aw = ^{s_axi.AWPROT, w_addr[ADDR_LSB-1:0]};

    always_comb begin
        w_next      = r_state;
        w_aw_held_n = r_aw_held;
        w_w_held_n  = r_w_held;
        unique case (r_state)
            W_IDLE: begin
                if (w_commit) begin
                    w_next      = W_RESP;
                    w_aw_held_n = 1'b0;
                    w_w_held_n  = 1'b0;
                end else begin
                    if (w_aw_hs) w_aw_held_n = 1'b1;
                    if (w_w_hs)  w_w_held_n  = 1'b1;
                end
            end
            W_RESP: begin
                if (s_axi.BREADY) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= W_IDLE;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            r_state   <= w_next;
            r_aw_held <= w_aw_held_n;
            r_w_held  <= w_w_held_n;
            // Readies are registered so they stay low during reset and rise
            // on the first edge after release.
            r_awready <= (w_next == W_IDLE) && !w_aw_held_n;
            r_wready  <= (w_next == W_IDLE) && !w_w_held_n;
            r_bvalid  <= (w_next == W_RESP);
            if (w_commit) r_bresp <= w_slverr ? RESP_SLVERR : RESP_OKAY;
            if (w_aw_hs)  r_awaddr <= s_axi.AWADDR;
            if (w_w_hs) begin
                r_wdata <= s_axi.WDATA;
                r_wstrb <= s_axi.WSTRB;
            end
        end
    end

    assign s_axi.AWREADY = r_awready;
    assign s_axi.WREADY  = r_wready;
    assign s_axi.BVALID  = r_bvalid;
    assign s_axi.BRESP   = r_bresp;

endmodule

// File: rtl/axi_lite_regbank.sv
// axi_lite_regbank
//   AXI4-Lite slave register bank with a fabric-side register port.
//   Ports:
//     S_AXI_ACLK, S_AXI_ARESET  clock, asynchronous active-high reset
//     s_axi                     AXI4-Lite slave bus
//     register_operation        fabric op: idle / read / write / set-bits
//     register_number           fabric register index
//     register_write            fabric write / set data
//     register_read             fabric read data (registered)
//     register_wr_strobe        per-register pulse after an OKAY AXI commit
module axi_lite_regbank
    import axi_lite_regbank_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH  = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH  = 6,
    parameter int unsigned NUMBER_OF_REGISTERS = 8,
    parameter logic [NUMBER_OF_REGISTERS-1:0] RO_MASK = '0
) (
    input  logic                           S_AXI_ACLK,
    input  logic                           S_AXI_ARESET,
    axi_lite_regbank_if.slave              s_axi,
    input  logic [1:0]                     register_operation,
    input  logic [7:0]                     register_number,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]  register_write,
    output logic [C_S_AXI_DATA_WIDTH-1:0]  register_read,
    output logic [NUMBER_OF_REGISTERS-1:0] register_wr_strobe
);

    localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
    localparam int unsigned AW       = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned N        = NUMBER_OF_REGISTERS;
    localparam int unsigned ADDR_LSB = addr_lsb(DW);
    localparam int unsigned IW       = AW - ADDR_LSB;

    logic [DW-1:0]   r_regs [N];
    logic [DW-1:0]   r_fab_rd, w_fab_val;
    logic [N-1:0]    r_wr_strobe;
    logic            w_commit_ok;
    logic [IW-1:0]   w_commit_idx, w_ar_idx;
    logic [DW-1:0]   w_commit_data, w_ar_val;
    logic [DW/8-1:0] w_commit_strb;
    logic            w_ar_hs, w_ar_in_range;
    r_state_t        r_rstate, w_rnext;
    logic            r_arready, r_rvalid;
    logic [DW-1:0]   r_rdata;
    logic [1:0]      r_rresp;
    logic            w_unused_ar;

    function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0]   old_v,
                                                 input logic [DW-1:0]   new_v,
                                                 input logic [DW/8-1:0] strb);
        apply_strb = old_v;
        for (int unsigned b = 0; b < DW / 8; b++)
            if (strb[b]) apply_strb[b*8 +: 8] = new_v[b*8 +: 8];
    endfunction

    axi_lite_regbank_wr_channel #(
        .DW      (DW),
        .AW      (AW),
        .N       (N),
        .RO_MASK (RO_MASK)
    ) u_wr_channel (
        .i_clk         (S_AXI_ACLK),
        .i_rst         (S_AXI_ARESET),
        .s_axi         (s_axi),
        .o_commit_ok   (w_commit_ok),
        .o_commit_idx  (w_commit_idx),
        .o_commit_data (w_commit_data),
        .o_commit_strb (w_commit_strb)
    );

    // Register storage: AXI commit first, fabric afterwards so the fabric
    // wins a same-register collision on the same edge.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            for (int unsigned i = 0; i < N; i++) r_regs[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (w_commit_ok && (32'(w_commit_idx) == i))
                    r_regs[i] <= apply_strb(r_regs[i], w_commit_data, w_commit_strb);
                if (register_number == 8'(i)) begin
                    case (register_operation)
                        REG_OP_WRITE: r_regs[i] <= register_write;
                        REG_OP_SET:   r_regs[i] <= r_regs[i] | register_write;
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_wr_strobe <= '0;
        end else begin
            for (int unsigned i = 0; i < N; i++)
                r_wr_strobe[i] <= w_commit_ok && (32'(w_commit_idx) == i);
        end
    end

    // Fabric read: out-of-range indices yield zero.
    always_comb begin
        w_fab_val = '0;
        for (int unsigned i = 0; i < N; i++)
            if (register_number == 8'(i)) w_fab_val = r_regs[i];
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET)                          r_fab_rd <= '0;
        else if (register_operation == REG_OP_READ) r_fab_rd <= w_fab_val;
    end

    // Read channel.
    assign w_ar_idx      = s_axi.ARADDR[AW-1:ADDR_LSB];
    assign w_ar_in_range = 32'(w_ar_idx) < N;
    assign w_ar_hs       = s_axi.ARVALID && r_arready;
    assign w_unused_ar   = ^{s_axi.ARPROT, s_axi.ARADDR[ADDR_LSB-1:0]};

    always_comb begin
        w_ar_val = '0;
        for (int unsigned i = 0; i < N; i++)
            if (32'(w_ar_idx) == i) w_ar_val = r_regs[i];
    end

    always_comb begin
        w_rnext = r_rstate;
        unique case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rnext = R_DATA;
            R_DATA:  if (s_axi.RREADY) w_rnext = R_IDLE;
            default: w_rnext = R_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) r_rstate <= R_IDLE;
        else              r_rstate <= w_rnext;
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            r_arready <= (w_rnext == R_IDLE);
            r_rvalid  <= (w_rnext == R_DATA);
            if (w_ar_hs) begin
                r_rdata <= w_ar_in_range ? w_ar_val : '0;
                r_rresp <= w_ar_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    assign s_axi.ARREADY      = r_arready;
    assign s_axi.RVALID       = r_rvalid;
    assign s_axi.RDATA        = r_rdata;
    assign s_axi.RRESP        = r_rresp;
    assign register_read      = r_fab_rd;
    assign register_wr_strobe = r_wr_strobe;

endmodule
